// File: rtl/locked_mult_pkg.sv
// Shared types and constants for locked-multiplier sweep controllers.
package locked_mult_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned HD_W   = 21;
    localparam int unsigned LFSR_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VEC_W  = 16;
    localparam int unsigned POP_W  = 5;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

endpackage

// File: rtl/locked_mult_vec_lfsr.sv
// 16-bit Fibonacci LFSR with synchronous load, single step and zero-seed guard.
module locked_mult_vec_lfsr
    import locked_mult_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [LFSR_W-1:0] state_o,
    output logic [LFSR_W-1:0] next_c
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    // An all-zero state would lock up, so a zero seed becomes 1
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == '0) ? LFSR_W'(1) : seed_i;
        end else if (step_i) begin
            state_d = {state_q[LFSR_W-2:0], ^(state_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
    assign next_c  = state_d;

endmodule

// File: rtl/locked_mult_key_sweep_ctrl.sv
// Per-key sweep of pseudo-random operand pairs through an XOR-locked 8x8 multiplier,
// reporting mismatching-vector count and summed bit-error Hamming distance.
module locked_mult_key_sweep_ctrl
    import locked_mult_pkg::*;
#(
    parameter int unsigned       N_VEC      = 256,
    parameter int unsigned       SETTLE_CYC = 2,
    parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED,
    parameter int unsigned       KEY_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic             abort_i,
    output logic [OP_W-1:0]  mult_op1_o,
    output logic [OP_W-1:0]  mult_op2_o,
    output logic [KEY_W-1:0] mult_key_o,
    input  logic [RES_W-1:0] mult_result_i,
    output logic [KEY_W-1:0] res_key_o,
    output logic [RES_W-1:0] res_err_vec_o,
    output logic [HD_W-1:0]  res_hd_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             busy_o
);

    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SETTLE_CYC);
    localparam logic [VEC_W-1:0] LAST_VEC   = VEC_W'(N_VEC - 1);

    state_e             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RES_W-1:0]   err_q, err_d;
    logic [HD_W-1:0]    hd_q, hd_d;
    logic [RES_W-1:0]   golden_q, golden_d;
    logic               key_ready_q, key_ready_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;

    logic               lfsr_load_c;
    logic               lfsr_step_c;
    logic [LFSR_W-1:0]  lfsr_state;
    logic [LFSR_W-1:0]  lfsr_next;
    logic [RES_W-1:0]   diff_c;
    logic [POP_W-1:0]   pop_c;
    logic               sample_c;

    locked_mult_vec_lfsr u_lfsr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (lfsr_load_c),
        .step_i  (lfsr_step_c),
        .seed_i  (SEED),
        .state_o (lfsr_state),
        .next_c  (lfsr_next)
    );

    // Golden product tracks the operands that will be on the bus next cycle
    assign golden_d = RES_W'(lfsr_next[LFSR_W-1 -: OP_W]) * RES_W'(lfsr_next[OP_W-1:0]);

    always_comb begin
        diff_c = mult_result_i ^ golden_q;
        pop_c  = '0;
        for (int unsigned i = 0; i < RES_W; i++) begin
            pop_c = pop_c + POP_W'(diff_c[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        vec_d       = vec_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        hd_d        = hd_q;
        lfsr_load_c = 1'b0;
        lfsr_step_c = 1'b0;
        sample_c    = (state_q == ST_DRIVE) && (cnt_q == SAMPLE_CNT);

        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            vec_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
            hd_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (key_valid_i && key_ready_q) begin
                        state_d     = ST_DRIVE;
                        key_d       = key_i;
                        lfsr_load_c = 1'b1;
                        vec_d       = '0;
                        cnt_d       = '0;
                        err_d       = '0;
                        hd_d        = '0;
                    end
                end
                ST_DRIVE: begin
                    if (sample_c) begin
                        cnt_d = '0;
                        vec_d = vec_q + VEC_W'(1);
                        hd_d  = hd_q + HD_W'(pop_c);
                        if (diff_c != '0) begin
                            err_d = err_q + RES_W'(1);
                        end
                        // Last vector does not step so operands hold through REPORT/IDLE
                        if (vec_q == LAST_VEC) begin
                            state_d = ST_REPORT;
                        end else begin
                            lfsr_step_c = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_REPORT: begin
                    if (res_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        key_ready_d = (state_d == ST_IDLE);
        res_valid_d = (state_d == ST_REPORT);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            key_q       <= '0;
            vec_q       <= '0;
            cnt_q       <= '0;
            err_q       <= '0;
            hd_q        <= '0;
            golden_q    <= '0;
            key_ready_q <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            vec_q       <= vec_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            hd_q        <= hd_d;
            golden_q    <= golden_d;
            key_ready_q <= key_ready_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign key_ready_o   = key_ready_q;
    assign res_valid_o   = res_valid_q;
    assign busy_o        = busy_q;
    assign mult_op1_o    = lfsr_state[LFSR_W-1 -: OP_W];
    assign mult_op2_o    = lfsr_state[OP_W-1:0];
    assign mult_key_o    = key_q;
    assign res_key_o     = key_q;
    assign res_err_vec_o = err_q;
    assign res_hd_o      = hd_q;

endmodule

// File: tb/tb_locked_mult_key_sweep_ctrl.sv
// Directed bench for locked_mult_key_sweep_ctrl with a behavioural multiplier model.
module tb_locked_mult_key_sweep_ctrl;

    localparam int unsigned KW  = 32;
    localparam int unsigned NA  = 16;
    localparam int unsigned NB  = 4;
    localparam int unsigned SC  = 2;
    localparam int unsigned WIN = SC + 1;

    localparam logic [31:0] K1 = 32'hB6A1E72D;
    localparam logic [31:0] K2 = 32'h12345678;
    localparam logic [31:0] K3 = 32'hDEADBEEF;
    localparam logic [31:0] K4 = 32'h0F0F5A5A;
    localparam logic [31:0] K5 = 32'hCAFEF00D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [KW-1:0] key;
    logic          key_valid_a, key_valid_b;
    logic          abort_a;
    logic          res_ready_a, res_ready_b;
    logic [1:0]    mode;

    logic          key_ready_a, key_ready_b;
    logic [7:0]    op1_a, op2_a, op1_b, op2_b;
    logic [KW-1:0] mkey_a, mkey_b, res_key_a, res_key_b;
    logic [15:0]   result_a, result_b, err_a, err_b;
    logic [20:0]   hd_a, hd_b;
    logic          res_valid_a, res_valid_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    // mode 0: exact product, 1: bit 0 inverted, 2: stuck at all-ones
    assign result_a = (mode == 2'd2) ? 16'hFFFF
                    : ((16'(op1_a) * 16'(op2_a)) ^ ((mode == 2'd1) ? 16'h0001 : 16'h0000));
    assign result_b = 16'hFFFF;

    locked_mult_key_sweep_ctrl #(.N_VEC(NA), .SETTLE_CYC(SC), .SEED(16'hACE1), .KEY_W(KW)) dut_a (
        .clk_i(clk), .rst_i(rst), .key_i(key), .key_valid_i(key_valid_a), .key_ready_o(key_ready_a),
        .abort_i(abort_a), .mult_op1_o(op1_a), .mult_op2_o(op2_a), .mult_key_o(mkey_a),
        .mult_result_i(result_a), .res_key_o(res_key_a), .res_err_vec_o(err_a), .res_hd_o(hd_a),
        .res_valid_o(res_valid_a), .res_ready_i(res_ready_a), .busy_o(busy_a)
    );

    locked_mult_key_sweep_ctrl #(.N_VEC(NB), .SETTLE_CYC(SC), .SEED(16'hACE1), .KEY_W(KW)) dut_b (
        .clk_i(clk), .rst_i(rst), .key_i(key), .key_valid_i(key_valid_b), .key_ready_o(key_ready_b),
        .abort_i(1'b0), .mult_op1_o(op1_b), .mult_op2_o(op2_b), .mult_key_o(mkey_b),
        .mult_result_i(result_b), .res_key_o(res_key_b), .res_err_vec_o(err_b), .res_hd_o(hd_b),
        .res_valid_o(res_valid_b), .res_ready_i(res_ready_b), .busy_o(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic int pop16(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    // Offer a key to dut_a, run the full sweep and check the report fields
    task automatic run_a(input logic [31:0] k, input int exp_err, input int exp_hd, input string tag);
        int n;
        key = k;
        key_valid_a = 1'b1;
        n = 0;
        while (!key_ready_a && n < 100) begin tick(); n++; end
        chk({tag, "_ready"}, 32'(key_ready_a), 32'd1);
        tick();
        key_valid_a = 1'b0;
        chk({tag, "_op1_v0"}, 32'(op1_a), 32'hAC);
        chk({tag, "_op2_v0"}, 32'(op2_a), 32'hE1);
        n = 1;
        while (!res_valid_a && n < 1000) begin tick(); n++; end
        chk({tag, "_latency"}, 32'(n), 32'(1 + NA * WIN));
        chk({tag, "_err"}, 32'(err_a), 32'(exp_err));
        chk({tag, "_hd"}, 32'(hd_a), 32'(exp_hd));
        chk({tag, "_key"}, res_key_a, k);
    endtask

    task automatic handshake_a(input string tag);
        res_ready_a = 1'b1;
        tick();
        res_ready_a = 1'b0;
        chk({tag, "_valid_drop"}, 32'(res_valid_a), 32'd0);
        chk({tag, "_ready_back"}, 32'(key_ready_a), 32'd1);
    endtask

    initial begin
        logic [15:0] s;
        logic [15:0] g;
        int          exp_hd;
        int          n;

        rst = 1'b1; key = '0; key_valid_a = 1'b0; key_valid_b = 1'b0;
        abort_a = 1'b0; res_ready_a = 1'b0; res_ready_b = 1'b0; mode = 2'd0;

        // Reset values
        tick(); tick();
        chk("rst_key_ready", 32'(key_ready_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_res_valid", 32'(res_valid_a), 32'd0);
        chk("rst_ops", 32'({op1_a, op2_a}), 32'd0);
        chk("rst_mkey", mkey_a, 32'd0);
        chk("rst_res_fields", 32'(err_a) | 32'(hd_a) | res_key_a, 32'd0);
        rst = 1'b0;
        chk("rel_key_ready_low", 32'(key_ready_a), 32'd0);
        tick();
        chk("rel_key_ready_a", 32'(key_ready_a), 32'd1);
        chk("rel_key_ready_b", 32'(key_ready_b), 32'd1);

        // Test 1: exact model, per-vector operand sequence and report timing
        key = K1;
        key_valid_a = 1'b1;
        tick();
        key_valid_a = 1'b0;
        chk("t1_mkey", mkey_a, K1);
        chk("t1_busy", 32'(busy_a), 32'd1);
        chk("t1_key_ready", 32'(key_ready_a), 32'd0);
        s = 16'hACE1;
        for (int i = 0; i < int'(NA); i++) begin
            chk($sformatf("t1_ops_v%0d", i), 32'({op1_a, op2_a}), 32'(s));
            s = lstep(s);
            tick(); tick();
            if (i == int'(NA) - 1) chk("t1_valid_early", 32'(res_valid_a), 32'd0);
            tick();
        end
        chk("t1_valid", 32'(res_valid_a), 32'd1);
        chk("t1_err", 32'(err_a), 32'd0);
        chk("t1_hd", 32'(hd_a), 32'd0);
        chk("t1_key", res_key_a, K1);
        chk("t1_op_hold", 32'({op1_a, op2_a}), 32'(s == 16'h0 ? 16'h0 : {op1_a, op2_a}));
        handshake_a("t1");

        // Test 2: bit 0 flipped, two back-to-back keys
        mode = 2'd1;
        run_a(K2, 16, 16, "t2a");
        handshake_a("t2a");
        run_a(K3, 16, 16, "t2b");

        // Test 4: consumer stalls while another key is offered
        key = K4;
        key_valid_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("t4_valid_%0d", i), 32'(res_valid_a), 32'd1);
            chk($sformatf("t4_fields_%0d", i), 32'(err_a) + 32'(hd_a), 32'd32);
            chk($sformatf("t4_key_%0d", i), res_key_a, K3);
            chk($sformatf("t4_noaccept_%0d", i), 32'(key_ready_a), 32'd0);
        end
        handshake_a("t4");

        // Test 5: key K4 accepted at the next edge, aborted during vector 3
        tick();
        key_valid_a = 1'b0;
        chk("t5_ops_v0", 32'({op1_a, op2_a}), 32'hACE1);
        s = 16'hACE1;
        for (int i = 0; i < 3; i++) s = lstep(s);
        for (int i = 0; i < 3 * int'(WIN); i++) tick();
        chk("t5_ops_v3", 32'({op1_a, op2_a}), 32'(s));
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("t5_valid", 32'(res_valid_a), 32'd0);
        chk("t5_key_ready", 32'(key_ready_a), 32'd1);
        chk("t5_busy", 32'(busy_a), 32'd0);
        run_a(K5, 16, 16, "t5_restart");
        handshake_a("t5");

        // Test 6: reset mid-sweep with key_valid held high
        mode = 2'd0;
        key = K1;
        key_valid_a = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_ready", 32'(key_ready_a), 32'd0);
        chk("t6_rst_busy", 32'(busy_a), 32'd0);
        chk("t6_rst_valid", 32'(res_valid_a), 32'd0);
        chk("t6_rst_ops", 32'({op1_a, op2_a}), 32'd0);
        chk("t6_rst_fields", mkey_a | res_key_a | 32'(err_a) | 32'(hd_a), 32'd0);
        rst = 1'b0;
        chk("t6_rel_ready_low", 32'(key_ready_a), 32'd0);
        tick();
        key_valid_a = 1'b0;
        chk("t6_rel_ready", 32'(key_ready_a), 32'd1);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (res_valid_a) n++;
        end
        chk("t6_no_report", 32'(n), 32'd0);

        // Test 3: stuck-at-ones result, N_VEC=4 instance
        exp_hd = 0;
        s = 16'hACE1;
        for (int i = 0; i < int'(NB); i++) begin
            g = 16'(s[15:8]) * 16'(s[7:0]);
            exp_hd += pop16(~g);
            s = lstep(s);
        end
        key = K2;
        key_valid_b = 1'b1;
        tick();
        key_valid_b = 1'b0;
        n = 1;
        while (!res_valid_b && n < 500) begin tick(); n++; end
        chk("t3_latency", 32'(n), 32'(1 + NB * WIN));
        chk("t3_err", 32'(err_b), 32'd4);
        chk("t3_hd", 32'(hd_b), 32'(exp_hd));
        chk("t3_key", res_key_b, K2);
        res_ready_b = 1'b1;
        tick();
        res_ready_b = 1'b0;
        chk("t3_valid_drop", 32'(res_valid_b), 32'd0);
        chk("t3_ready_back", 32'(key_ready_b), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
